// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//   Bundles the fetch stage's instruction-memory bus, redirect input and
//   decode-side handshake.
//   master : the fetch unit (drives imem_req/imem_addr and the id_* outputs)
//   slave  : memory, branch resolution and decode (drive ack/rvalid/rdata,
//            redirect_* and id_ready)
//   Signals:
//     imem_req, imem_addr        fetch request and byte address
//     imem_ack                   memory accepted the request
//     imem_rvalid, imem_rdata    in-order response word
//     redirect_valid, redirect_pc  branch/JALR redirect
//     id_ready                   decode accepts the head instruction
//     id_valid, id_instr, id_opcode, id_pc  head instruction to decode
interface fetch_unit_if #(
  parameter int PC_W = 9
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            id_ready;
  logic            id_valid;
  logic [31:0]     id_instr;
  logic [6:0]      id_opcode;
  logic [PC_W-1:0] id_pc;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_opcode, id_pc,
    input  imem_ack, imem_rvalid, imem_rdata, redirect_valid, redirect_pc,
           id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_opcode, id_pc,
    output imem_ack, imem_rvalid, imem_rdata, redirect_valid, redirect_pc,
           id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage. Holds the PC, issues in-order requests to
//   instruction memory under a credit limit of DEPTH (buffered + in flight),
//   buffers returned words with their PCs in a small FIFO and presents the
//   head to decode. A redirect reloads the PC, clears the FIFO and marks
//   every still-outstanding response for discard.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      fetch_unit_if master modport (memory bus, redirect, decode)
module fetch_unit #(
  parameter int          PC_W     = 9,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_unit_if.master bus
);

  localparam int          CW  = $clog2(DEPTH + 1);
  localparam int          PW  = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [PC_W-1:0] pc;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   discard;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  logic [31:0]     fifo_instr [DEPTH];
  logic [PC_W-1:0] fifo_pc    [DEPTH];

  logic [CW:0]     used;
  logic            has_credit;
  logic            accept;
  logic            rsp_take;
  logic            drop;
  logic            push;
  logic            pop;
  logic [PC_W-1:0] rsp_pc;
  logic            unused_lsb;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Target word alignment: the two low bits of a redirect are ignored.
  assign unused_lsb = ^bus.redirect_pc[1:0];

  // Credit covers buffered words plus outstanding requests, so a response
  // always has a free slot. A pop this cycle does not free credit yet.
  assign used       = {1'b0, cnt} + {1'b0, inflight};
  assign has_credit = used < (CW + 1)'(DEPTH);

  assign bus.imem_req  = reset_n && !bus.redirect_valid && has_credit;
  assign bus.imem_addr = pc;

  assign accept   = bus.imem_req && bus.imem_ack;
  assign rsp_take = bus.imem_rvalid && (inflight != '0);
  assign drop     = bus.imem_rvalid && (discard != '0);
  assign push     = bus.imem_rvalid && (discard == '0) && !bus.redirect_valid;
  assign pop      = (cnt != '0) && bus.id_ready;

  // Once discards are exhausted, every outstanding request belongs to the
  // current contiguous stream ending just below pc, so the oldest one (the
  // one answering now) sits inflight words back. Wraps modulo 2^PC_W.
  assign rsp_pc = pc - (PC_W'(inflight) << 2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= PC_W'(RESET_PC);
      cnt      <= '0;
      inflight <= '0;
      discard  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (bus.redirect_valid) begin
      // No request is issued while redirecting, so only a response can
      // retire here; everything still outstanding afterwards is stale.
      pc       <= {bus.redirect_pc[PC_W-1:2], 2'b00};
      cnt      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= inflight - CW'(rsp_take);
      discard  <= inflight - CW'(rsp_take);
    end else begin
      if (accept) begin
        pc <= pc + PC_W'(4);
      end
      inflight <= inflight + CW'(accept) - CW'(rsp_take);
      if (drop) begin
        discard <= discard - CW'(1);
      end
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: the head is only exposed while cnt != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= bus.imem_rdata;
      fifo_pc[wr_ptr]    <= rsp_pc;
    end
  end

  assign bus.id_valid  = (cnt != '0);
  assign bus.id_instr  = bus.id_valid ? fifo_instr[rd_ptr] : NOP;
  assign bus.id_opcode = bus.id_instr[6:0];
  assign bus.id_pc     = bus.id_valid ? fifo_pc[rd_ptr] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int          PC_W     = 9;
  localparam int          DEPTH    = 4;
  localparam int          RESET_PC = 0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.PC_W(PC_W)) bus ();

  fetch_unit #(.PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Pipelined instruction memory: word = request address, latency lat_m1+1.
  logic [1:0]      lat_m1 = 2'd0;
  logic [3:0]      pv;
  logic [PC_W-1:0] pa [4];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pv <= '0;
    end else begin
      pv    <= {pv[2:0], bus.imem_req & bus.imem_ack};
      pa[0] <= bus.imem_addr;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
    end
  end

  assign bus.imem_rvalid = pv[lat_m1];
  assign bus.imem_rdata  = {{(32 - PC_W){1'b0}}, pa[lat_m1]};

  always @(negedge clk) begin
    if (reset_n && bus.imem_rvalid) begin
      assert (dut.inflight != 0) else $error("response with nothing in flight");
      assert (!(dut.discard == 0 && dut.cnt == DEPTH)) else $error("fifo overflow on response");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard: expected PCs pushed when a request is acknowledged,
  // flushed on redirect/reset, popped when decode takes an instruction.
  logic [PC_W-1:0] exp_q [$];
  logic [PC_W-1:0] exp_fetch;
  logic            last_acc;
  logic            last_pop;
  logic [PC_W-1:0] last_addr;

  task automatic step();
    logic acc, pop;
    logic [PC_W-1:0] e;
    #1;
    acc = 1'b0;
    pop = 1'b0;
    if (reset_n) begin
      acc = bus.imem_req & bus.imem_ack;
      pop = bus.id_valid & bus.id_ready;
      if (bus.redirect_valid) begin
        vectors++;
        if (bus.imem_req !== 1'b0) begin
          miscompares++;
          $display("FAIL redirect_req got %b want 0", bus.imem_req);
        end
        exp_q.delete();
        exp_fetch = {bus.redirect_pc[PC_W-1:2], 2'b00};
        pop = 1'b0;
      end
      if (acc) begin
        vectors++;
        if (bus.imem_addr !== exp_fetch) begin
          miscompares++;
          $display("FAIL fetch_addr got %h want %h", bus.imem_addr, exp_fetch);
        end
        exp_q.push_back(exp_fetch);
        exp_fetch = exp_fetch + PC_W'(4);
      end
      if (pop) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL id_unexpected got pc %h want no instruction", bus.id_pc);
        end else begin
          e = exp_q.pop_front();
          if (bus.id_pc !== e || bus.id_instr !== {{(32 - PC_W){1'b0}}, e} ||
              bus.id_opcode !== e[6:0]) begin
            miscompares++;
            $display("FAIL id_head got pc %h instr %h op %h want pc %h instr %h",
                     bus.id_pc, bus.id_instr, bus.id_opcode, e, {{(32 - PC_W){1'b0}}, e});
          end
        end
      end
      if (!bus.id_valid) begin
        vectors++;
        if (bus.id_instr !== NOP || bus.id_pc !== '0 || bus.id_opcode !== 7'h13) begin
          miscompares++;
          $display("FAIL idle_outputs got instr %h pc %h want %h 0", bus.id_instr, bus.id_pc, NOP);
        end
      end
    end
    last_acc  = acc;
    last_pop  = pop;
    last_addr = bus.imem_addr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] l);
    @(negedge clk);
    reset_n            = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_ack       = 1'b1;
    bus.id_ready       = 1'b1;
    @(negedge clk);
    lat_m1 = l;
    @(negedge clk);
    exp_q.delete();
    exp_fetch = PC_W'(RESET_PC);
    reset_n   = 1'b1;
  endtask

  task automatic test_reset();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_ack       = 1'b1;
    bus.id_ready       = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors += 6;
    if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b want 0", bus.imem_req); end
    if (bus.imem_addr !== PC_W'(RESET_PC)) begin miscompares++; $display("FAIL rst_addr got %h want %h", bus.imem_addr, RESET_PC); end
    if (bus.id_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", bus.id_valid); end
    if (bus.id_instr !== NOP) begin miscompares++; $display("FAIL rst_instr got %h want %h", bus.id_instr, NOP); end
    if (bus.id_opcode !== 7'b0010011) begin miscompares++; $display("FAIL rst_opcode got %b want 0010011", bus.id_opcode); end
    if (bus.id_pc !== '0) begin miscompares++; $display("FAIL rst_pc got %h want 0", bus.id_pc); end
    @(negedge clk);
    exp_q.delete();
    exp_fetch = PC_W'(RESET_PC);
    reset_n   = 1'b1;
    #1;
    vectors++;
    if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL first_req got %b want 1", bus.imem_req); end
    step();
  endtask

  task automatic test_stream();
    int n;
    repeat (4) step();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_pop) n++;
    end
    vectors++;
    if (n != 20) begin miscompares++; $display("FAIL stream_rate got %0d want 20", n); end
  endtask

  task automatic test_stall();
    logic v0;
    logic [PC_W-1:0] p0;
    logic [31:0] i0;
    int n;
    bus.id_ready = 1'b0;
    v0 = bus.id_valid;
    p0 = bus.id_pc;
    i0 = bus.id_instr;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (bus.id_valid !== v0 || bus.id_pc !== p0 || bus.id_instr !== i0) begin
        miscompares++;
        $display("FAIL stall_hold got %b %h %h want %b %h %h", bus.id_valid, bus.id_pc, bus.id_instr, v0, p0, i0);
      end
    end
    #1;
    vectors += 3;
    if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_req got %b want 0", bus.imem_req); end
    if (dut.cnt !== 3'd4) begin miscompares++; $display("FAIL stall_cnt got %0d want 4", dut.cnt); end
    if (dut.inflight !== 3'd0) begin miscompares++; $display("FAIL stall_inflight got %0d want 0", dut.inflight); end
    bus.id_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (last_pop) n++;
    end
    vectors++;
    if (n != 12) begin miscompares++; $display("FAIL stall_resume got %0d want 12", n); end
  endtask

  task automatic redirect_and_check(input logic [PC_W-1:0] target, input string tag);
    int occ;
    logic [PC_W-1:0] aligned;
    aligned            = {target[PC_W-1:2], 2'b00};
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    occ = 0;
    for (int k = 0; k <= 3; k++) if (k <= int'(lat_m1) && pv[k]) occ++;
    occ = occ - (bus.imem_rvalid ? 1 : 0);
    step();
    bus.redirect_valid = 1'b0;
    #1;
    vectors += 2;
    if (dut.discard !== 3'(occ)) begin
      miscompares++;
      $display("FAIL %s discard got %0d want %0d", tag, dut.discard, occ);
    end
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== aligned) begin
      miscompares++;
      $display("FAIL %s target_req got %b %h want 1 %h", tag, bus.imem_req, bus.imem_addr, aligned);
    end
  endtask

  task automatic test_redirect_lat3();
    logic found;
    do_reset(2'd2);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dut.cnt == 1 && dut.inflight == 2) begin found = 1'b1; break; end
      step();
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL lat3_setup got timeout want cnt1 inflight2"); end
    redirect_and_check(PC_W'('h40), "lat3");
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.id_valid) begin found = 1'b1; break; end
      step();
    end
    vectors++;
    if (!found || bus.id_pc !== PC_W'('h40)) begin
      miscompares++;
      $display("FAIL lat3_first got valid %b pc %h want 1 040", found, bus.id_pc);
    end
    repeat (10) step();
  endtask

  task automatic test_redirect_same_rvalid();
    do_reset(2'd0);
    repeat (6) step();
    #1;
    vectors++;
    if (bus.imem_rvalid !== 1'b1) begin miscompares++; $display("FAIL same_setup got rvalid %b want 1", bus.imem_rvalid); end
    redirect_and_check(PC_W'('h43), "same_rvalid");
    repeat (10) step();
  endtask

  task automatic test_wrap();
    logic [PC_W-1:0] tbl [3];
    tbl[0] = PC_W'('h1F8);
    tbl[1] = PC_W'('h1FC);
    tbl[2] = PC_W'('h000);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = PC_W'('h1F8);
    step();
    bus.redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (last_acc !== 1'b1 || last_addr !== tbl[k]) begin
        miscompares++;
        $display("FAIL wrap_addr%0d got %b %h want 1 %h", k, last_acc, last_addr, tbl[k]);
      end
    end
    repeat (10) step();
  endtask

  task automatic test_reset_midstream();
    logic found;
    bus.id_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dut.cnt == 3) begin found = 1'b1; break; end
      step();
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL midrst_setup got timeout want cnt3"); end
    #2 reset_n = 1'b0;
    #1;
    vectors += 3;
    if (bus.id_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got %b want 0", bus.id_valid); end
    if (bus.id_instr !== NOP) begin miscompares++; $display("FAIL midrst_instr got %h want %h", bus.id_instr, NOP); end
    if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL midrst_req got %b want 0", bus.imem_req); end
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    exp_fetch    = PC_W'(RESET_PC);
    bus.id_ready = 1'b1;
    reset_n      = 1'b1;
    step();
    vectors++;
    if (last_acc !== 1'b1 || last_addr !== PC_W'(RESET_PC)) begin
      miscompares++;
      $display("FAIL midrst_restart got %b %h want 1 %h", last_acc, last_addr, RESET_PC);
    end
    repeat (15) step();
  endtask

  task automatic test_random(input logic [1:0] l);
    do_reset(l);
    for (int i = 0; i < 300; i++) begin
      bus.imem_ack       = ($urandom_range(0, 3) != 0);
      bus.id_ready       = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 15) == 0);
      bus.redirect_pc    = PC_W'($urandom_range(0, 511));
      step();
    end
    bus.imem_ack       = 1'b1;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    repeat (20) step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_lat3();
    test_redirect_same_rvalid();
    test_wrap();
    test_reset_midstream();
    test_random(2'd0);
    test_random(2'd2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V pipeline. It holds the PC and issues in-order requests to instruction memory. Returned words are buffered in a small FIFO and presented to the decode stage, whose opcode field drives the main Controller. It also handles redirects from resolved branches and JALR by flushing buffered and in-flight instructions.

## Interface
- PC_W, 9: PC / instruction-memory byte-address width.
- DEPTH, 4: instruction FIFO depth. This is also the credit limit on in-flight plus buffered fetches. Must be ≥2.
- RESET_PC, 0: PC value after reset.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  PC_W→1  fetch request valid (1 bit).
- imem_addr  out  PC_W  fetch byte address; always equals current PC.
- imem_ack  in  1  memory accepted the request this cycle. Only meaningful while imem_req=1.
- imem_rvalid  in  1  response valid. Responses return in request order, ≥1 cycle after ack.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  branch taken / JALR resolved this cycle.
- redirect_pc  in  PC_W  redirect target; bits [1:0] are ignored and forced to 0.
- id_ready  in  1  decode accepts the head instruction (0 = stall).
- id_valid  out  1  head instruction valid.
- id_instr  out  32  head instruction, or 32'h00000013 (addi x0,x0,0) when id_valid=0.
- id_opcode  out  7  id_instr[6:0]; feeds the Controller Opcode input.
- id_pc  out  PC_W  PC of head instruction; 0 when id_valid=0.

## Operation
State:
- pc register.
- FIFO of {instr, pc}, DEPTH entries, with count `cnt`.
- `inflight` counter: accepted requests not yet responded.
- `discard` counter: in-flight responses to drop. Always `discard` ≤ `inflight`.
- All counters are $clog2(DEPTH+1) bits wide.

Rules:
- Credit: imem_req = !redirect_valid && (cnt + inflight < DEPTH). Combinational from registered state plus redirect_valid. A pop in the current cycle does not add credit in that cycle.
- Accept (imem_req && imem_ack): pc ← pc+4, modulo 2^PC_W (wraps to 0); inflight+1.
- Response (imem_rvalid):
  - inflight−1 in all cases.
  - If discard>0: word dropped, discard−1.
  - Otherwise: {imem_rdata, PC of that request} is pushed. The request's PC comes from a parallel in-flight PC queue or a recomputed value; either is acceptable, but it must be exact.
- Pop: id_valid && id_ready removes the head.
- Redirect (has priority over everything):
  - pc ← {redirect_pc[PC_W-1:2], 2'b00}.
  - FIFO cleared; cnt ← 0.
  - discard ← inflight − (imem_rvalid ? 1 : 0). The response arriving this cycle is dropped.
  - A pop in the same cycle is irrelevant, since the FIFO is cleared.
- Push and pop in the same cycle: cnt unchanged. Legal at cnt=DEPTH because credit guarantees no push when full.
- Overflow (rvalid with discard=0 and cnt=DEPTH) cannot occur under credit. The bench checks this with an assertion.
- rvalid with inflight=0 is a protocol error. The bench asserts on it.

## Timing
- Reset (asynchronous assert, synchronous release):
  - pc=RESET_PC; cnt=inflight=discard=0.
  - imem_req=0 while reset_n=0. imem_addr=RESET_PC.
  - id_valid=0, id_instr=32'h00000013, id_opcode=7'b0010011, id_pc=0.
- First imem_req=1 in the first cycle after reset_n rises.
- Instruction memory shares reset; no pre-reset responses return. Reset mid-operation discards everything.
- Latency: a response at edge t is visible on id_* from t+1. There is no combinational rdata→id bypass.
- Redirect latency:
  - Redirect asserted in cycle N.
  - imem_req=1 with the target address in N+1.
  - With a 1-cycle memory, the target instruction is on id_* in N+3.
- Throughput: with a 1-cycle memory and id_ready=1, steady state is 1 instruction per cycle for DEPTH≥3.
- id_* are driven from the FIFO head register. They are stable while id_ready=0.

## Test plan
- Reset then free-run, 1-cycle memory returning word = address, id_ready=1 → id_pc sequence 0,4,8,…. After the first fill, one instruction per cycle. id_instr==id_pc.
- Hold id_ready=0 for 10 cycles → cnt reaches 4, inflight=0, imem_req=0. id_* unchanged. On release, 4 pops then streaming resumes with no gap or duplicate.
- 3-cycle memory latency, redirect_valid to 0x40 while inflight=2 and cnt=1 → both stale responses dropped. Next id_valid shows id_pc=0x40. No instruction with pc≠0x40 follows the redirect.
- Redirect with redirect_pc=0x43 in the same cycle as imem_rvalid and id_ready=1 → that response dropped. Next fetch address 0x40. discard = inflight−1.
- PC_W=9 running from 0x1F8 → addresses 0x1F8, 0x1FC, 0x000. id_pc wraps identically.
- Assert reset_n low mid-stream with cnt=3 → id_valid=0 and id_instr=0x00000013 immediately (asynchronous). After release, fetch restarts at RESET_PC.
